// File: rtl/gbuf_read_arbiter.sv
// gbuf_read_arbiter
//   Shares the global-buffer read port among N_REQ processing elements. Requesters
//   are served round-robin. Each grant issues one locked burst of len+1 consecutive
//   read beats starting at the requester's base address. The owner then gets a
//   one-cycle done pulse.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   req_i         per-PE burst request, held until the PE sees its done pulse
//   req_addr_i    per-PE base address, PE i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len_i     per-PE burst length minus one, PE i at [i*LEN_WIDTH +: LEN_WIDTH]
//   gbuf_ready_i  buffer accepts the presented beat this cycle
//   gbuf_ren_o    read-beat valid toward the buffer
//   gbuf_addr_o   address of the presented beat
//   grant_o       one-hot port owner, zero when idle
//   done_o        one-cycle pulse to the owner after its last beat is accepted
//   busy_o        high while a burst or its done cycle is in progress
//
// Every output is a register, so no input reaches an output combinationally.
module gbuf_read_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [N_REQ*LEN_WIDTH-1:0]    req_len_i,
    input  logic                          gbuf_ready_i,
    output logic                          gbuf_ren_o,
    output logic [ADDR_WIDTH-1:0]         gbuf_addr_o,
    output logic [N_REQ-1:0]              grant_o,
    output logic [N_REQ-1:0]              done_o,
    output logic                          busy_o
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDone
    } state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        ptr_q;
    logic [IdxW-1:0]        winner_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beat_cnt_q;

    logic                   ren_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [N_REQ-1:0]       grant_q;
    logic [N_REQ-1:0]       done_q;
    logic                   busy_q;

    logic                   win_valid;
    logic [IdxW-1:0]        win_idx;
    logic [IdxW-1:0]        cand;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [LEN_WIDTH-1:0]   win_len;

    function automatic logic [N_REQ-1:0] onehot(input logic [IdxW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search. Offsets are walked from the farthest to the nearest, so the
    // set bit closest to ptr_q (cyclically) is the last one written and wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            cand = IdxW'((int'(ptr_q) + i) % int'(N_REQ));
            if (req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's address and length fields with constant part-selects.
    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_idx == IdxW'(i)) begin
                win_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_len  = req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            winner_q   <= '0;
            base_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            ren_q      <= 1'b0;
            addr_q     <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= '0;
                    if (win_valid) begin
                        state_q    <= StBurst;
                        winner_q   <= win_idx;
                        base_q     <= win_addr;
                        len_q      <= win_len;
                        beat_cnt_q <= '0;
                        ren_q      <= 1'b1;
                        addr_q     <= win_addr;
                        grant_q    <= onehot(win_idx);
                        busy_q     <= 1'b1;
                    end
                end

                // Request inputs are not looked at here: the burst is locked to the
                // values captured at grant time.
                StBurst: begin
                    if (ren_q && gbuf_ready_i) begin
                        if (beat_cnt_q == len_q) begin
                            state_q <= StDone;
                            ren_q   <= 1'b0;
                            addr_q  <= '0;
                            grant_q <= '0;
                            done_q  <= onehot(winner_q);
                        end else begin
                            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                            // Address wraps modulo 2^ADDR_WIDTH.
                            addr_q     <= base_q + ADDR_WIDTH'(beat_cnt_q) + ADDR_WIDTH'(1);
                        end
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= (winner_q == IdxW'(N_REQ - 1)) ? '0 : winner_q + IdxW'(1);
                end

                default: begin
                    state_q <= StIdle;
                    ren_q   <= 1'b0;
                    grant_q <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gbuf_ren_o  = ren_q;
    assign gbuf_addr_o = addr_q;
    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/gbuf_read_arbiter.md
GBUF_READ_ARBITER -- requirements
Module: gbuf_read_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of PE requesters sharing the global-buffer read port.
REQ-002 Parameter ADDR_WIDTH, default 8, global-buffer address width.
REQ-003 Parameter LEN_WIDTH, default 4, burst-length field width; a burst is len+1 beats.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  N_REQ  per-PE burst request; held by the PE until its done pulse.
REQ-008 req_addr  input  N_REQ*ADDR_WIDTH  per-PE base address; PE i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_len  input  N_REQ*LEN_WIDTH  per-PE burst length minus one; same packing as req_addr.
REQ-010 gbuf_ready  input  1  buffer accepts the presented read beat this cycle.
REQ-011 gbuf_ren  output  1  read-beat valid toward the buffer.
REQ-012 gbuf_addr  output  ADDR_WIDTH  address of the presented beat.
REQ-013 grant  output  N_REQ  one-hot owner of the port; all zero when idle.
REQ-014 done  output  N_REQ  one-cycle pulse to the owner after its last beat is accepted.
REQ-015 busy  output  1  high in BURST and DONE states.

Function
REQ-016 FSM states: IDLE, BURST and DONE; all outputs are decoded from the registered state and registers only, with no combinational path from any input to any output.
REQ-017 IDLE: grant=0, gbuf_ren=0, done=0; if any req bit is set, latch the winner index, its req_addr into base and its req_len into len_q, clear beat_cnt, and go to BURST next cycle.
REQ-018 Arbitration is round-robin: search req cyclically starting at pointer ptr; the first set bit wins.
REQ-019 Grant latency: a req first seen in IDLE at cycle t produces grant and gbuf_ren at cycle t+1.
REQ-020 BURST: grant = one-hot(winner), gbuf_ren=1, gbuf_addr = base + beat_cnt, computed modulo 2^ADDR_WIDTH (wraps, no carry out).
REQ-021 A beat is accepted when gbuf_ren && gbuf_ready; only then does beat_cnt increment.
REQ-022 With gbuf_ready=0, gbuf_addr, grant and beat_cnt hold unchanged for any number of cycles.
REQ-023 When the beat with beat_cnt==len_q is accepted, go to DONE; len_q=0 gives a single-beat burst.
REQ-024 DONE: done[winner]=1 for exactly one cycle, grant=0, gbuf_ren=0; set ptr = (winner+1) mod N_REQ; go to IDLE.
REQ-025 A burst is locked once granted: changes to req, req_addr or req_len during BURST or DONE are ignored, including the owner dropping req.
REQ-026 A requester still asserting req in IDLE after its done pulse is rearbitrated normally; the minimum gap between bursts is one IDLE cycle.
REQ-027 With N_REQ requesters continuously requesting, each one is granted exactly once per N_REQ bursts, so no requester starves.

Reset
REQ-028 On rst=1 at a clock edge, whatever the state (including mid-burst), the next state is IDLE with ptr=0, beat_cnt=0, winner=0, base=0 and len_q=0.
REQ-029 While in reset and the cycle after it, grant=0, done=0, gbuf_ren=0, gbuf_addr=0 and busy=0; an interrupted burst produces no done pulse.

Verification
REQ-030 Single burst: after reset, req=4'b0100, addr2=0x10, len2=3, gbuf_ready=1 held -> grant=0100 for 4 cycles; gbuf_addr=0x10,0x11,0x12,0x13; done=0100 on the next cycle; ptr=3.
REQ-031 Fairness: req=4'b1111 held from reset, len=0 for all -> grant order 0001,0010,0100,1000,0001; each grant is followed by one DONE cycle and one IDLE cycle.
REQ-032 Backpressure: len=1 burst with gbuf_ready=0 for 3 cycles on the first beat -> gbuf_addr holds base for 4 cycles; only 2 beats are accepted in total; done fires once.
REQ-033 Wrap: addr=0xFE, len=3 -> gbuf_addr=0xFE,0xFF,0x00,0x01.
REQ-034 Reset mid-burst: rst during the 2nd beat of a len=3 burst -> next cycle grant=0, gbuf_ren=0, no done pulse; a subsequent req=4'b1010 grants PE1 first (ptr=0).
REQ-035 Lock: the owner drops req and changes req_addr after the 1st beat of a len=2 burst -> 3 beats are still issued from the original base, and done is asserted for that owner.
